lab1_imul_int_mul_var_lat: RTL and testbench



---
 rtl/lab1_imul_int_mul_var_lat.sv | 119 +++++++++++
 tb/tb_lab1_imul_int_mul_var_lat.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lab1_imul_int_mul_var_lat.sv
// Variable-latency iterative integer multiplier (signed/unsigned, full-width product).
// Shift-add datapath that stops as soon as the remaining multiplier bits are all zero.
module lab1_imul_int_mul_var_lat #(
  parameter int unsigned NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*NBITS:0]   req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [2*NBITS-1:0] resp_msg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [2*NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0]   b_q, b_d;
  logic [2*NBITS-1:0] acc_q, acc_d;
  logic [2*NBITS-1:0] resp_q, resp_d;
  logic               neg_q, neg_d;

  logic               signed_mode;
  logic [NBITS-1:0]   a_raw, b_raw;
  logic [NBITS-1:0]   a_mag, b_mag;
  logic               req_fire;

  assign signed_mode = req_msg[2*NBITS];
  assign a_raw       = req_msg[2*NBITS-1:NBITS];
  assign b_raw       = req_msg[NBITS-1:0];

  // The most negative operand negates to itself, which is exactly its magnitude read unsigned.
  assign a_mag = (signed_mode && a_raw[NBITS-1]) ? -a_raw : a_raw;
  assign b_mag = (signed_mode && b_raw[NBITS-1]) ? -b_raw : b_raw;

  assign req_fire = req_val && req_rdy;

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      resp_q  <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      resp_q  <= resp_d;
      neg_q   <= neg_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_fire)     state_d = CALC;
      CALC: if (b_q == '0)    state_d = DONE;
      DONE: if (resp_rdy)     state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    resp_d = resp_q;
    neg_d  = neg_q;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          a_d   = {{NBITS{1'b0}}, a_mag};
          b_d   = b_mag;
          neg_d = signed_mode && (a_raw[NBITS-1] ^ b_raw[NBITS-1]);
          acc_d = '0;
        end
      end
      CALC: begin
        if (b_q == '0) begin
          // Sign is applied once here; the magnitude product never exceeds 2*NBITS bits.
          resp_d = neg_q ? -acc_q : acc_q;
        end else begin
          acc_d = acc_q + (b_q[0] ? a_q : '0);
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    resp_msg = resp_q;
    unique case (state_q)
      IDLE:    req_rdy  = 1'b1;
      DONE:    resp_val = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lab1_imul_int_mul_var_lat.sv
// Scoreboard bench for lab1_imul_int_mul_var_lat: driver pushes expected products,
// an independent monitor pops and compares value and response latency.
module tb_lab1_imul_int_mul_var_lat;

  localparam int NBITS = 32;

  logic               clk;
  logic               reset;
  logic               req_val;
  logic               req_rdy;
  logic [2*NBITS:0]   req_msg;
  logic               resp_val;
  logic               resp_rdy;
  logic [2*NBITS-1:0] resp_msg;

  lab1_imul_int_mul_var_lat #(.NBITS(NBITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  typedef struct {
    logic [63:0] msg;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   fire_q[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int resp_seen = 0;
  int mon_lat;
  logic prev_val = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: compares every cycle resp_val is high; latency is measured on the rising cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_val = 1'b0;
    end else begin
      if (resp_val) begin
        if (sb_q.size() == 0) begin
          check("unexpected response (resp_val with empty scoreboard)", {63'd0, resp_val}, 64'd0);
        end else begin
          if (!prev_val) begin
            resp_seen++;
            mon_lat = (fire_q.size() != 0) ? (cyc - fire_q.pop_front() + 1) : -1;
            check({"latency ", sb_q[0].name}, 64'(mon_lat), 64'(sb_q[0].lat));
          end
          check({"product ", sb_q[0].name}, resp_msg, sb_q[0].msg);
          if (resp_rdy) void'(sb_q.pop_front());
        end
      end
      prev_val = resp_val;
      if (req_val && req_rdy) fire_q.push_back(cyc + 1);
    end
  end

  task automatic send(input logic sm, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp, input int lat, input string name);
    bit fired = 0;
    @(posedge clk); #1;
    req_val = 1'b1;
    req_msg = {sm, a, b};
    for (int i = 0; i < 100 && !fired; i++) begin
      @(negedge clk);
      if (req_rdy) fired = 1;
    end
    if (!fired) check({"req_rdy timeout ", name}, 64'd0, 64'd1);
    else sb_q.push_back('{exp, lat, name});
    @(posedge clk); #1;
    req_val = 1'b0;
    req_msg = {1'b0, $urandom(), $urandom()};
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check({"drain ", name}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, f1, nf;
    bit seen;
    reset    = 1'b1;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b1;
    #3;
    check("reset req_rdy",  {63'd0, req_rdy},  64'd1);
    check("reset resp_val", {63'd0, resp_val}, 64'd0);
    check("reset resp_msg", resp_msg, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    send(1'b0, 32'h0000_0003, 32'h0000_0004, 64'h0000_0000_0000_000C, 5, "u 3x4");
    drain("u 3x4");
    send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 34, "u max x max");
    drain("u max x max");
    send(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 3, "s -1x-1");
    drain("s -1x-1");
    send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 3, "s min x -1");
    drain("s min x -1");
    send(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 4, "s 7x-2");
    drain("s 7x-2");

    // b=0 back-to-back with req_val held high.
    @(posedge clk); #1;
    req_val = 1'b1;
    req_msg = {1'b0, 32'h1234_5678, 32'h0000_0000};
    f0 = 0; f1 = 0; nf = 0;
    for (int i = 0; i < 40 && nf < 2; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        if (nf == 0) f0 = cyc + 1; else f1 = cyc + 1;
        nf++;
        sb_q.push_back('{64'd0, 2, "u b0"});
      end
    end
    @(posedge clk); #1;
    req_val = 1'b0;
    check("b0 fire count", 64'(nf), 64'd2);
    check("b0 fire spacing (edges)", 64'(f1 - f0), 64'd3);
    drain("u b0 pair");

    // Backpressure: response held while new requests are offered.
    resp_rdy = 1'b0;
    send(1'b0, 32'h0000_0006, 32'h0000_0009, 64'h0000_0000_0000_0036, 6, "u 6x9 backpressure");
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (resp_val) seen = 1;
    end
    check("backpressure resp_val seen", {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
    req_val = 1'b1;
    req_msg = {1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("backpressure req_rdy", {63'd0, req_rdy}, 64'd0);
      check("backpressure resp_val", {63'd0, resp_val}, 64'd1);
    end
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    req_val  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("req_rdy one cycle after resp_rdy", {63'd0, req_rdy}, 64'd1);
    drain("backpressure");

    // Asynchronous reset in the middle of a long computation.
    send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 34, "aborted");
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid-calc reset req_rdy",  {63'd0, req_rdy},  64'd1);
    check("mid-calc reset resp_val", {63'd0, resp_val}, 64'd0);
    check("mid-calc reset resp_msg", resp_msg, 64'd0);
    sb_q.delete();
    fire_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    send(1'b0, 32'h0000_0005, 32'h0000_0005, 64'h0000_0000_0000_0019, 5, "u 5x5 after reset");
    drain("u 5x5 after reset");
    repeat (40) @(negedge clk);
    check("total responses", 64'(resp_seen), 64'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
